// File: rtl/fx_ga_tmc_if.sv
// Register bus of the TMC gate-array window: select, strobes, data and the interrupt line.
interface fx_ga_tmc_if;
    logic        A7;
    logic        A6;
    logic        CSn;
    logic        RDn;
    logic        WRn;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        INT;

    modport master (
        output A7, A6, CSn, RDn, WRn, DI,
        input  DO, INT
    );

    modport slave (
        input  A7, A6, CSn, RDn, WRn, DI,
        output DO, INT
    );
endinterface

// File: rtl/fx_ga_tmc.sv
// PC-FX gate-array Timer Control Unit: 16-bit down-counting interval timer behind a fixed
// prescaler. CTRL/PERIOD/COUNT live at {A7,A6} = 00/10/11; INT feeds ITC source 6.
module fx_ga_tmc #(
    parameter int unsigned PRESCALE = 15
) (
    input logic         CLK,
    input logic         RES,
    input logic         CE,
    fx_ga_tmc_if.slave  bus
);

    localparam int unsigned PW = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] PLast = PW'(PRESCALE - 1);

    logic            te_q, te_d;
    logic            tie_q, tie_d;
    logic            tis_q, tis_d;
    logic [15:0]     period_q, period_d;
    logic [16:0]     cnt_q, cnt_d;
    logic [PW-1:0]   presc_q, presc_d;

    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic        ctrl_wr;
    logic        per_wr;
    logic        en_edge;
    logic        tick;
    logic        tick_kept;
    logic [16:0] reload_val;

    assign addr    = {bus.A7, bus.A6};
    assign wr_en   = ~bus.CSn & ~bus.WRn;
    assign rd_en   = ~bus.CSn & ~bus.RDn;
    assign ctrl_wr = wr_en & (addr == 2'b00);
    assign per_wr  = wr_en & (addr == 2'b10);

    // Only a 0->1 transition of TE reloads, so a held write reloads once.
    assign en_edge = ctrl_wr & ~te_q & bus.DI[0];
    assign tick    = te_q & (presc_q == PLast);
    // A disabling CTRL write drops a coinciding tick: counter keeps its pre-tick value.
    assign tick_kept  = tick & ~(ctrl_wr & ~bus.DI[0]);
    // PERIOD of 0 means a full 65536-tick interval, hence the 17-bit counter.
    assign reload_val = (period_q == 16'd0) ? 17'h10000 : {1'b0, period_q};

    // Next-state: register writes, enable-edge reload, prescaler and counter stepping.
    always_comb begin
        te_d     = te_q;
        tie_d    = tie_q;
        tis_d    = tis_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        presc_d  = presc_q;

        if (ctrl_wr) begin
            te_d  = bus.DI[0];
            tie_d = bus.DI[1];
            if (!bus.DI[2]) begin
                tis_d = 1'b0;
            end
        end

        if (per_wr) begin
            period_d = bus.DI;
        end

        if (en_edge) begin
            cnt_d   = reload_val;
            presc_d = '0;
        end else if (te_q) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick_kept) begin
                if (cnt_q == 17'd1) begin
                    cnt_d = reload_val;
                    // Placed after the CTRL clear so a same-cycle set wins.
                    tis_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 17'd1;
                end
            end
        end
    end

    // State registers, advanced only on clock-enabled cycles; RES is synchronous.
    always_ff @(posedge CLK) begin
        if (CE) begin
            if (RES) begin
                te_q     <= 1'b0;
                tie_q    <= 1'b0;
                tis_q    <= 1'b0;
                period_q <= 16'd0;
                cnt_q    <= 17'd0;
                presc_q  <= '0;
            end else begin
                te_q     <= te_d;
                tie_q    <= tie_d;
                tis_q    <= tis_d;
                period_q <= period_d;
                cnt_q    <= cnt_d;
                presc_q  <= presc_d;
            end
        end
    end

    // Combinational read mux; the bus floats to zero when not being read.
    always_comb begin
        bus.DO = 16'd0;
        if (rd_en) begin
            case (addr)
                2'b00:   bus.DO = {13'd0, tis_q, tie_q, te_q};
                2'b10:   bus.DO = period_q;
                2'b11:   bus.DO = cnt_q[15:0];
                default: bus.DO = 16'd0;
            endcase
        end
    end

    assign bus.INT = tis_q & tie_q;

endmodule

// File: tb/tb_fx_ga_tmc.sv
// Directed bench for fx_ga_tmc: one DUT with PRESCALE=15 (index 0), one with PRESCALE=1 (index 1).
module tb_fx_ga_tmc;

    localparam logic [1:0] ACtrl = 2'b00;
    localparam logic [1:0] ARsv  = 2'b01;
    localparam logic [1:0] APer  = 2'b10;
    localparam logic [1:0] ACnt  = 2'b11;

    logic        clk;
    logic [1:0]  res;
    logic [1:0]  ce;
    logic [1:0]  a7, a6, csn, rdn, wrn;
    logic [15:0] di [2];

    int n_checks;
    int n_pass;

    fx_ga_tmc_if bus15 ();
    fx_ga_tmc_if bus1 ();

    assign bus15.A7  = a7[0];
    assign bus15.A6  = a6[0];
    assign bus15.CSn = csn[0];
    assign bus15.RDn = rdn[0];
    assign bus15.WRn = wrn[0];
    assign bus15.DI  = di[0];
    assign bus1.A7   = a7[1];
    assign bus1.A6   = a6[1];
    assign bus1.CSn  = csn[1];
    assign bus1.RDn  = rdn[1];
    assign bus1.WRn  = wrn[1];
    assign bus1.DI   = di[1];

    fx_ga_tmc #(.PRESCALE(15)) u_dut15 (
        .CLK (clk),
        .RES (res[0]),
        .CE  (ce[0]),
        .bus (bus15)
    );

    fx_ga_tmc #(.PRESCALE(1)) u_dut1 (
        .CLK (clk),
        .RES (res[1]),
        .CE  (ce[1]),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [15:0] v);
        a7[d]  = a[1];
        a6[d]  = a[0];
        di[d]  = v;
        csn[d] = 1'b0;
        wrn[d] = 1'b0;
        cyc();
        csn[d] = 1'b1;
        wrn[d] = 1'b1;
    endtask

    task automatic rd(input int d, input logic [1:0] a, output logic [15:0] v);
        a7[d]  = a[1];
        a6[d]  = a[0];
        csn[d] = 1'b0;
        rdn[d] = 1'b0;
        #1;
        v = (d == 0) ? bus15.DO : bus1.DO;
        csn[d] = 1'b1;
        rdn[d] = 1'b1;
    endtask

    function automatic logic get_int(input int d);
        return (d == 0) ? bus15.INT : bus1.INT;
    endfunction

    task automatic do_reset(input int d, input int n);
        res[d] = 1'b1;
        cycn(n);
        res[d] = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        do_reset(0, 2);
        do_reset(1, 2);
        for (int d = 0; d < 2; d++) begin
            rd(d, ACtrl, v);
            n_checks++;
            if (v !== 16'h0000) $display("FAIL reset_ctrl dut%0d got %h exp 0000", d, v);
            else n_pass++;
            rd(d, APer, v);
            n_checks++;
            if (v !== 16'h0000) $display("FAIL reset_period dut%0d got %h exp 0000", d, v);
            else n_pass++;
            rd(d, ACnt, v);
            n_checks++;
            if (v !== 16'h0000) $display("FAIL reset_count dut%0d got %h exp 0000", d, v);
            else n_pass++;
            n_checks++;
            if (get_int(d) !== 1'b0) $display("FAIL reset_int dut%0d got %b exp 0", d, get_int(d));
            else n_pass++;
        end
    endtask

    task automatic test_basic_period();
        logic [15:0] v;
        wr(0, APer, 16'd3);
        wr(0, ACtrl, 16'h0003);
        rd(0, ACnt, v);
        n_checks++;
        if (v !== 16'd3) $display("FAIL basic_count0 got %0d exp 3", v);
        else n_pass++;
        for (int k = 1; k <= 90; k++) begin
            // Clear TIS while staying enabled; TE already 1 so no reload.
            if (k == 46) wr(0, ACtrl, 16'h0003);
            else cyc();
            if (k == 14 || k == 15 || k == 30 || k == 45) begin
                rd(0, ACnt, v);
                n_checks++;
                if (v !== ((k == 14) ? 16'd3 : (k == 15) ? 16'd2 : (k == 30) ? 16'd1 : 16'd3))
                    $display("FAIL basic_count_k%0d got %0d", k, v);
                else n_pass++;
            end
            if (k == 44 || k == 46 || k == 89) begin
                n_checks++;
                if (get_int(0) !== 1'b0) $display("FAIL basic_int_low_k%0d got %b exp 0", k, get_int(0));
                else n_pass++;
            end
            if (k == 45 || k == 90) begin
                n_checks++;
                if (get_int(0) !== 1'b1) $display("FAIL basic_int_high_k%0d got %b exp 1", k, get_int(0));
                else n_pass++;
                rd(0, ACtrl, v);
                n_checks++;
                if (v !== 16'h0007) $display("FAIL basic_ctrl_k%0d got %h exp 0007", k, v);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ce_gating();
        logic [15:0] v;
        do_reset(0, 1);
        ce[0] = 1'b0;
        wr(0, ACtrl, 16'h0003);
        ce[0] = 1'b1;
        rd(0, ACtrl, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL ce_low_write got %h exp 0000", v);
        else n_pass++;
        wr(0, APer, 16'd1);
        wr(0, ACtrl, 16'h0003);
        ce[0] = 1'b0;
        // 14 enabled cycles interleaved with stalled ones: one short of the tick.
        for (int i = 0; i < 14; i++) begin
            ce[0] = 1'b1;
            cyc();
            ce[0] = 1'b0;
            cyc();
        end
        n_checks++;
        if (get_int(0) !== 1'b0) $display("FAIL ce_int_early got %b exp 0", get_int(0));
        else n_pass++;
        ce[0] = 1'b1;
        cyc();
        n_checks++;
        if (get_int(0) !== 1'b1) $display("FAIL ce_int_tick got %b exp 1", get_int(0));
        else n_pass++;
    endtask

    task automatic test_period0();
        logic [15:0] v;
        wr(1, APer, 16'd0);
        wr(1, ACtrl, 16'h0001);
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL p0_count_full got %h exp 0000", v);
        else n_pass++;
        cyc();
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'hFFFF) $display("FAIL p0_count_first got %h exp ffff", v);
        else n_pass++;
        cycn(65534);
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0001) $display("FAIL p0_tis_early got %h exp 0001", v);
        else n_pass++;
        cyc();
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0005) $display("FAIL p0_tis_set got %h exp 0005", v);
        else n_pass++;
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL p0_count_reload got %h exp 0000", v);
        else n_pass++;
    endtask

    task automatic test_clear_race();
        logic [15:0] v;
        do_reset(1, 1);
        wr(1, APer, 16'd2);
        wr(1, ACtrl, 16'h0003);
        cycn(2);
        n_checks++;
        if (get_int(1) !== 1'b1) $display("FAIL race_first_set got %b exp 1", get_int(1));
        else n_pass++;
        wr(1, ACtrl, 16'h0003);
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0003) $display("FAIL race_clear got %h exp 0003", v);
        else n_pass++;
        // Counter is now 1: this write lands on the setting tick.
        wr(1, ACtrl, 16'h0003);
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0007) $display("FAIL race_set_wins got %h exp 0007", v);
        else n_pass++;
        wr(1, ACtrl, 16'h0005);
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0005) $display("FAIL race_tie_off_ctrl got %h exp 0005", v);
        else n_pass++;
        n_checks++;
        if (get_int(1) !== 1'b0) $display("FAIL race_tie_off_int got %b exp 0", get_int(1));
        else n_pass++;
        rd(1, ARsv, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL race_reserved got %h exp 0000", v);
        else n_pass++;
    endtask

    task automatic test_hold_reenable();
        logic [15:0] v;
        do_reset(1, 1);
        wr(1, APer, 16'd10);
        wr(1, ACtrl, 16'h0001);
        cycn(4);
        wr(1, ACtrl, 16'h0000);
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'd6) $display("FAIL hold_disable got %0d exp 6", v);
        else n_pass++;
        cycn(20);
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'd6) $display("FAIL hold_20 got %0d exp 6", v);
        else n_pass++;
        wr(1, APer, 16'd4);
        wr(1, ACnt, 16'd99);
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'd6) $display("FAIL hold_period_wr got %0d exp 6", v);
        else n_pass++;
        wr(1, ACtrl, 16'h0001);
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'd4) $display("FAIL reenable_load got %0d exp 4", v);
        else n_pass++;
        wr(1, APer, 16'd7);
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'd3) $display("FAIL period_change_cur got %0d exp 3", v);
        else n_pass++;
        cycn(2);
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0001) $display("FAIL period_change_early got %h exp 0001", v);
        else n_pass++;
        cyc();
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'd7) $display("FAIL period_change_reload got %0d exp 7", v);
        else n_pass++;
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0005) $display("FAIL period_change_tis got %h exp 0005", v);
        else n_pass++;
    endtask

    task automatic test_midcount_reset();
        logic [15:0] v;
        do_reset(1, 1);
        wr(1, APer, 16'd8);
        wr(1, ACtrl, 16'h0003);
        cycn(3);
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'd5) $display("FAIL mid_before got %0d exp 5", v);
        else n_pass++;
        do_reset(1, 1);
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL mid_ctrl got %h exp 0000", v);
        else n_pass++;
        rd(1, APer, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL mid_period got %h exp 0000", v);
        else n_pass++;
        rd(1, ACnt, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL mid_count got %h exp 0000", v);
        else n_pass++;
        cycn(20);
        n_checks++;
        if (get_int(1) !== 1'b0) $display("FAIL mid_int got %b exp 0", get_int(1));
        else n_pass++;
        rd(1, ACtrl, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL mid_no_tick got %h exp 0000", v);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        res = 2'b00;
        ce  = 2'b11;
        a7  = 2'b00;
        a6  = 2'b00;
        csn = 2'b11;
        rdn = 2'b11;
        wrn = 2'b11;
        di[0] = 16'd0;
        di[1] = 16'd0;
        #2;
        test_reset();
        test_basic_period();
        test_ce_gating();
        test_period0();
        test_clear_race();
        test_hold_reenable();
        test_midcount_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
